sdram_tester: RTL
=================

SDRAM_TESTER -- requirements
Module: sdram_tester

Interface
REQ-001 Parameter ADDR_W, default 24, SDRAM word-address width (16-bit words).
REQ-002 Parameter LAST_ADDR, default {ADDR_W{1'b1}}, highest word address tested per pass.
REQ-003 Parameter MAX_OUT, default 4, maximum outstanding reads (1..15).
REQ-004 CLOCK_100  in  1  sole clock; all logic rises on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 button  in  1  start/re-arm request, level, already synchronized to CLOCK_100.
REQ-007 mem_req  out  1  command valid to SDRAM controller.
REQ-008 mem_we  out  1  1 = write, 0 = read; valid with mem_req.
REQ-009 mem_addr  out  ADDR_W  word address; valid with mem_req.
REQ-010 mem_wdata  out  16  write data; valid with mem_req & mem_we.
REQ-011 mem_ready  in  1  controller accepts command in any cycle with mem_req & mem_ready.
REQ-012 mem_rdata  in  16  read data; valid with mem_rvalid.
REQ-013 mem_rvalid  in  1  one read word returned, in issue order.
REQ-014 led  out  8  status display.

Function
REQ-015 States: IDLE, WRITE, READ, DRAIN, FAIL.
REQ-016 Start event = button high in current cycle, low in previous cycle (internal edge detect).
REQ-017 IDLE: mem_req=0; start -> WRITE with waddr=0; iter unchanged.
REQ-018 Pattern P(a,i) = a[15:0] XOR 16'hA55A XOR {8'h00, i[7:0]}; address bits above 15 ignored; i = 8-bit iteration counter.
REQ-019 WRITE: mem_req=1, mem_we=1, mem_addr=waddr, mem_wdata=P(waddr,iter); on accept waddr+1; accept at LAST_ADDR -> READ with raddr=0, caddr=0, outstanding=0.
REQ-020 mem_req/mem_addr/mem_wdata/mem_we SHALL hold stable while mem_req=1 and mem_ready=0.
REQ-021 READ: mem_req=1, mem_we=0, mem_addr=raddr only while outstanding < MAX_OUT; on accept raddr+1, outstanding+1; accept at LAST_ADDR -> DRAIN.
REQ-022 Outstanding: +1 on read accept, -1 on mem_rvalid; simultaneous accept and rvalid leaves it unchanged.
REQ-023 Compare on each mem_rvalid in READ or DRAIN: expected P(caddr,iter); caddr+1 after compare.
REQ-024 Mismatch: latch fail_addr=caddr, fail_data=mem_rdata (first mismatch only), go FAIL next cycle; issuing stops immediately.
REQ-025 DRAIN: mem_req=0; when outstanding reaches 0 with no mismatch -> iter+1 (wraps 255->0), WRITE with waddr=0.
REQ-026 mem_rvalid while outstanding=0 SHALL be ignored (no compare, no counter change).
REQ-027 FAIL: mem_req=0; remaining mem_rvalid ignored; start -> IDLE clearing fail flag, iter=0.
REQ-028 Start in WRITE/READ/DRAIN SHALL be ignored.
REQ-029 led[7]=fail flag; led[6]=1 in WRITE/READ/DRAIN; led[5:0]=iter[5:0] outside FAIL, fail_addr[5:0] in FAIL.
REQ-030 Address counters are ADDR_W wide; LAST_ADDR={ADDR_W{1'b1}} wraps naturally to 0 at pass end.

Reset
REQ-031 On rst: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, led=8'h00, iter=0, counters/outstanding=0, fail flag 0, edge-detect history cleared to 1 (button held through reset does not start).
REQ-032 rst mid-operation SHALL abandon all outstanding reads; subsequent mem_rvalid ignored per REQ-026.

Verification (LAST_ADDR=7, MAX_OUT=4, ideal memory model, latency 3)
REQ-033 Reset, button pulse, mem_ready=1 -> 8 writes addr 0..7, data 16'hA55A..16'hA55D pattern (addr0=A55A, addr1=A55B), then 8 reads, then second write pass with iter=1 (addr0 data A55B); led=8'h41 during pass 2.
REQ-034 mem_ready held 0 for 5 cycles mid-WRITE -> mem_addr/mem_wdata unchanged across stall, no skipped address.
REQ-035 Memory returns no rvalid -> exactly 4 reads issued (addr 0..3), mem_req low until rvalid arrives.
REQ-036 Model corrupts addr 5 in pass 0 -> FAIL, led=8'h85, no further mem_req; button pulse -> IDLE, led=8'h00.
REQ-037 rst asserted with 3 reads outstanding -> next cycle IDLE, mem_req=0, late rvalids cause no state change.
REQ-038 button held high across reset release -> stays IDLE until button goes low then high.

Source files
------------

// File: rtl/sdram_tester.sv
// SDRAM pattern tester: writes an address/iteration pattern over the tested range,
// reads it back with a bounded number of outstanding reads, and halts on the first mismatch.
module sdram_tester #(
  parameter int unsigned       ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
  parameter int unsigned       MAX_OUT   = 4
) (
  input  logic              CLOCK_100,
  input  logic              rst,
  input  logic              button,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [7:0]        led
);

  typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN, ST_FAIL} state_t;

  localparam logic [3:0] MAX_OUT_W = 4'(MAX_OUT);

  state_t            state, state_n;
  logic [7:0]        iter, iter_n;
  logic [ADDR_W-1:0] waddr, waddr_n, raddr, raddr_n, caddr, caddr_n;
  logic [3:0]        outstanding, out_n;
  logic              fail_flag, fail_n;
  logic [5:0]        fail_addr, fail_addr_n;
  logic [15:0]       fail_data, fail_data_n;
  logic              btn_prev;

  logic              start, accept, rd_acc, rv, mismatch, busy_n;
  logic              req_n, we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       wdata_n;
  logic [7:0]        led_n;

  // fail_data has no port; kept as a probe point for on-chip debug
  logic unused_fail_data;
  assign unused_fail_data = ^fail_data;

  function automatic logic [15:0] pat(input logic [15:0] a, input logic [7:0] i);
    return a ^ 16'hA55A ^ {8'h00, i};
  endfunction

  always_comb begin
    start    = button & ~btn_prev;
    accept   = mem_req & mem_ready;
    rd_acc   = 1'b0;
    rv       = mem_rvalid && (outstanding != '0) &&
               (state == ST_READ || state == ST_DRAIN);
    mismatch = rv && (mem_rdata != pat(16'(caddr), iter));

    state_n     = state;
    iter_n      = iter;
    waddr_n     = waddr;
    raddr_n     = raddr;
    caddr_n     = caddr;
    out_n       = outstanding;
    fail_n      = fail_flag;
    fail_addr_n = fail_addr;
    fail_data_n = fail_data;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_WRITE;
          waddr_n = '0;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          waddr_n = waddr + 1'b1;
          if (waddr == LAST_ADDR) begin
            state_n = ST_READ;
            raddr_n = '0;
            caddr_n = '0;
            out_n   = '0;
          end
        end
      end
      ST_READ, ST_DRAIN: begin
        rd_acc = (state == ST_READ) && accept;
        out_n  = outstanding + {3'b000, rd_acc} - {3'b000, rv};
        if (rd_acc) begin
          raddr_n = raddr + 1'b1;
          if (raddr == LAST_ADDR) state_n = ST_DRAIN;
        end
        if (rv) caddr_n = caddr + 1'b1;
        if (mismatch) begin
          state_n     = ST_FAIL;
          fail_n      = 1'b1;
          fail_addr_n = 6'(caddr);
          fail_data_n = mem_rdata;
        end else if (state == ST_DRAIN && out_n == '0) begin
          state_n = ST_WRITE;
          iter_n  = iter + 1'b1;
          waddr_n = '0;
        end
      end
      ST_FAIL: begin
        if (start) begin
          state_n = ST_IDLE;
          fail_n  = 1'b0;
          iter_n  = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Outputs are registered from next-state values so a stalled command holds unchanged
    busy_n  = (state_n == ST_WRITE) || (state_n == ST_READ) || (state_n == ST_DRAIN);
    req_n   = (state_n == ST_WRITE) || (state_n == ST_READ && out_n < MAX_OUT_W);
    we_n    = (state_n == ST_WRITE);
    addr_n  = (state_n == ST_WRITE) ? waddr_n :
              (state_n == ST_READ)  ? raddr_n : '0;
    wdata_n = (state_n == ST_WRITE) ? pat(16'(waddr_n), iter_n) : '0;
    led_n   = {fail_n, busy_n, (state_n == ST_FAIL) ? fail_addr_n : iter_n[5:0]};
  end

  always_ff @(posedge CLOCK_100) begin
    if (rst) begin
      state       <= ST_IDLE;
      iter        <= '0;
      waddr       <= '0;
      raddr       <= '0;
      caddr       <= '0;
      outstanding <= '0;
      fail_flag   <= 1'b0;
      fail_addr   <= '0;
      fail_data   <= '0;
      btn_prev    <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      led         <= '0;
    end else begin
      state       <= state_n;
      iter        <= iter_n;
      waddr       <= waddr_n;
      raddr       <= raddr_n;
      caddr       <= caddr_n;
      outstanding <= out_n;
      fail_flag   <= fail_n;
      fail_addr   <= fail_addr_n;
      fail_data   <= fail_data_n;
      btn_prev    <= button;
      mem_req     <= req_n;
      mem_we      <= we_n;
      mem_addr    <= addr_n;
      mem_wdata   <= wdata_n;
      led         <= led_n;
    end
  end

endmodule
